// File: rtl/mosbius_pkg.sv
// rtl/mosbius_pkg.sv - shared FSM encoding and bit-order helpers for the shift-chain loader
package mosbius_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4,
    FINISH   = 3'd5
  } state_t;

  localparam bit MSB_FIRST = 1'b1;

  // Bit idx (0 = first on the wire) of a config byte.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
    return MSB_FIRST ? b[3'd7 - idx] : b[idx];
  endfunction

  // Accumulate a readback bit in wire order.
  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
    return MSB_FIRST ? {r[6:0], b} : {b, r[7:1]};
  endfunction

endpackage

// File: rtl/mosbius_clkdiv.sv
// rtl/mosbius_clkdiv.sv - CLK_DIV-cycle phase counter with first/last cycle strobes
module mosbius_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_first,
  output logic phase_end
);

  logic [7:0] cnt;

  assign phase_first = en && (cnt == 8'd0);
  assign phase_end   = en && (cnt == 8'(CLK_DIV - 1));

  // Restarts at zero whenever a phase ends or the counter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (!en || phase_end) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mosbius_cfg_loader.sv
// rtl/mosbius_cfg_loader.sv - streams config bytes into the switch-matrix shift chain with readback
module mosbius_cfg_loader #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             sr_clk,
  output logic             sr_dat,
  output logic             sr_latch,
  input  logic             sr_dout,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done
);
  import mosbius_pkg::*;

  state_t           state, state_next;
  logic [LEN_W-1:0] bytes_left;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg, rb, rb_next;
  logic             div_en, phase_first, phase_end, last_bit, fetch_hs;

  assign div_en   = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);
  assign last_bit = (bit_cnt == 3'd7);
  assign fetch_hs = (state == FETCH) && byte_valid;
  assign rb_next  = phase_first ? shift_in(rb, sr_dout) : rb;

  mosbius_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (div_en),
    .phase_first(phase_first),
    .phase_end  (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = (len == '0) ? FINISH : FETCH;
      FETCH:    if (byte_valid) state_next = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_end) begin
          if (!last_bit)                      state_next = SHIFT_LO;
          else if (bytes_left != LEN_W'(1))   state_next = FETCH;
          else                                state_next = LATCH;
        end
      end
      LATCH:    if (phase_end) state_next = FINISH;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    sr_clk     = 1'b0;
    sr_latch   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    byte_ready = (state == FETCH);
    sr_clk     = (state == SHIFT_HI);
    sr_latch   = (state == LATCH);
    busy       = (state != IDLE);
    done       = (state == FINISH);
  end

  // sr_dat only moves on SHIFT_LO entry, so it is always settled before sr_clk rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_left <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      rb         <= 8'd0;
      sr_dat     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
    end else begin
      rd_valid <= 1'b0;
      if ((state == IDLE) && start) begin
        bytes_left <= len;
        bit_cnt    <= 3'd0;
      end
      if (fetch_hs) begin
        shreg   <= byte_data;
        bit_cnt <= 3'd0;
        sr_dat  <= pick_bit(byte_data, 3'd0);
      end
      if (state == SHIFT_HI) begin
        rb <= rb_next;
        if (phase_end) begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 3'd1;
            sr_dat  <= pick_bit(shreg, bit_cnt + 3'd1);
          end else begin
            rd_valid   <= 1'b1;
            rd_data    <= rb_next;
            bytes_left <= bytes_left - LEN_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/mosbius_cfg_loader.md
MOSBIUS_CFG_LOADER -- requirements
Module: mosbius_cfg_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sr_clk half-period in clk cycles, legal 1..255.
REQ-002 SHALL have parameter LEN_W, default 8: width of the byte-count input.
REQ-003 SHALL have port clk  in  1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  in  1: one-cycle request to load a frame.
REQ-006 SHALL have port len  in  LEN_W: frame length in bytes, sampled when start is accepted.
REQ-007 SHALL have ports byte_valid in 1, byte_data in 8, byte_ready out 1: config byte stream, valid/ready.
REQ-008 SHALL have ports sr_clk out 1, sr_dat out 1, sr_latch out 1: drive the switch-matrix shift chain (clk/dat_in/enable).
REQ-009 SHALL have port sr_dout  in  1: chain serial output (dat_out), for readback.
REQ-010 SHALL have ports rd_valid out 1, rd_data out 8: readback byte stream, no backpressure.
REQ-011 SHALL have ports busy out 1, done out 1: frame in progress; one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, FINISH.
REQ-013 SHALL, in IDLE, accept start when high; len latched, bit counter cleared, next state FETCH (len!=0) or FINISH (len==0, no sr_clk/sr_latch activity).
REQ-014 SHALL ignore start whenever busy is high.
REQ-015 SHALL, in FETCH, assert byte_ready; on byte_valid&byte_ready load byte_data into the shift register and go to SHIFT_LO.
REQ-016 SHALL stall in FETCH indefinitely while byte_valid is low, holding sr_clk low and sr_dat stable.
REQ-017 SHALL shift each byte MSB first: sr_dat updated on SHIFT_LO entry and held through the following SHIFT_HI.
REQ-018 SHALL hold SHIFT_LO and SHIFT_HI each for exactly CLK_DIV clk cycles; sr_clk low in SHIFT_LO, high in SHIFT_HI.
REQ-019 SHALL sample sr_dout in the first cycle of SHIFT_HI into an 8-bit readback register, MSB first.
REQ-020 SHALL, after the 8th bit of a byte, pulse rd_valid for one cycle with the completed readback byte at SHIFT_HI exit.
REQ-021 SHALL, at SHIFT_HI exit, go to SHIFT_LO if bits remain in the byte, FETCH if bytes remain, else LATCH.
REQ-022 SHALL, in LATCH, hold sr_clk low and sr_latch high for CLK_DIV cycles, then go to FINISH.
REQ-023 SHALL, in FINISH, pulse done for one cycle and return to IDLE.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL never change sr_dat in the same cycle sr_clk rises.
REQ-026 SHALL treat a frame of len bytes as exactly 8*len sr_clk rising edges.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE and counters to zero.
REQ-028 SHALL reset outputs: sr_clk 0, sr_dat 0, sr_latch 0, byte_ready 0, rd_valid 0, rd_data 0, busy 0, done 0.
REQ-029 SHALL, on reset mid-frame, abandon the frame with no latch pulse and no done pulse.

Structure
REQ-030 SHALL place FSM state enum and the MSB-first bit-order constant in shared package mosbius_pkg.
REQ-031 SHALL use one sub-module, mosbius_clkdiv, a CLK_DIV-cycle phase counter emitting a phase-end strobe.

Verification
REQ-032 SHALL cover: CLK_DIV=1, len=1, byte 0xA5 -> sr_dat on successive rising edges 1,0,1,0,0,1,0,1; one 1-cycle latch pulse; done once.
REQ-033 SHALL cover: sr_dout model = 8-bit chain preloaded 0x3C, len=1 byte 0xFF -> rd_data 0x3C with single rd_valid.
REQ-034 SHALL cover: len=3, byte_valid withheld 20 cycles before byte 2 -> sr_clk low throughout gap, exactly 24 rising edges total.
REQ-035 SHALL cover: len=0 start -> done one cycle later via FINISH, zero sr_clk edges, no sr_latch.
REQ-036 SHALL cover: rst_n low after 5th rising edge of len=2 frame -> all outputs at reset values, no done; new start runs normally.
REQ-037 SHALL cover: start re-asserted while busy (CLK_DIV=4, len=2) -> ignored, exactly 16 edges, one done.
